// File: rtl/cpu_clock_ctrl_if.sv
// Signal bundle between the clock controller and its switches, button, core enable and LED.
// With CE_COUNT_EN defined the bundle also carries the 32-bit cpu_ce pulse count.
interface cpu_clock_ctrl_if;
    logic [1:0]  mode;
    logic        step_btn;
    logic        cpu_ce;
    logic        heartbeat;
    logic [1:0]  state;
`ifdef CE_COUNT_EN
    logic [31:0] ce_count;

    modport master (output mode, output step_btn,
                    input cpu_ce, input heartbeat, input state, input ce_count);
    modport slave  (input mode, input step_btn,
                    output cpu_ce, output heartbeat, output state, output ce_count);
`else
    modport master (output mode, output step_btn,
                    input cpu_ce, input heartbeat, input state);
    modport slave  (input mode, input step_btn,
                    output cpu_ce, output heartbeat, output state);
`endif
endinterface

// File: rtl/cpu_clock_ctrl.sv
// Core clock-enable sequencer: HALT / FAST / SLOW tick / debounced single-step on clk_50Mhz.
// Define CE_COUNT_EN to add the 32-bit cpu_ce pulse counter (bus.ce_count).
//
// state | meaning
// ------+-------------------------------------------------
// HALT  | core stopped, cpu_ce held low
// FAST  | cpu_ce high every cycle after the entry cycle
// SLOW  | one cpu_ce every SLOW_DIV cycles, heartbeat toggles
// STEP  | one cpu_ce per debounced button press
module cpu_clock_ctrl #(
    parameter int XTAL_FREQ       = 50_000_000,
    parameter int SLOW_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk_50Mhz,
    input  logic             reset_n,
    cpu_clock_ctrl_if.slave  bus
);

    localparam int SLOW_DIV = XTAL_FREQ / SLOW_HZ;
    localparam int SLOW_W   = $clog2(SLOW_DIV);
    localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_FAST = 2'b01,
        ST_SLOW = 2'b10,
        ST_STEP = 2'b11
    } state_t;

    logic [1:0]        mode_s1, mode_s2;
    logic              btn_s1, btn_s2;
    logic              btn_acc, btn_acc_d;
    logic [DB_W-1:0]   db_cnt;
    logic              step_edge;

    state_t            state_q;
    logic              cpu_ce_q;
    logic              heartbeat_q;
    logic [SLOW_W-1:0] slow_cnt;

    always_ff @(posedge clk_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            mode_s1 <= 2'b00;
            mode_s2 <= 2'b00;
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
        end else begin
            mode_s1 <= bus.mode;
            mode_s2 <= mode_s1;
            btn_s1  <= bus.step_btn;
            btn_s2  <= btn_s1;
        end
    end

    // The accepted level only follows the synced button after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            btn_acc   <= 1'b0;
            btn_acc_d <= 1'b0;
            db_cnt    <= '0;
        end else begin
            btn_acc_d <= btn_acc;
            if (btn_s2 == btn_acc) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_acc <= btn_s2;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign step_edge = btn_acc & ~btn_acc_d;

    // A pending mode change takes priority, so a step edge that coincides with it is dropped.
    always_ff @(posedge clk_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HALT;
            cpu_ce_q    <= 1'b0;
            heartbeat_q <= 1'b0;
            slow_cnt    <= '0;
        end else if (mode_s2 != state_q) begin
            state_q  <= state_t'(mode_s2);
            cpu_ce_q <= 1'b0;
            slow_cnt <= '0;
        end else begin
            cpu_ce_q <= 1'b0;
            case (state_q)
                ST_HALT: cpu_ce_q <= 1'b0;
                ST_FAST: cpu_ce_q <= 1'b1;
                ST_SLOW: begin
                    if (slow_cnt == SLOW_LAST) begin
                        slow_cnt    <= '0;
                        cpu_ce_q    <= 1'b1;
                        heartbeat_q <= ~heartbeat_q;
                    end else begin
                        slow_cnt <= slow_cnt + SLOW_W'(1);
                    end
                end
                ST_STEP: cpu_ce_q <= step_edge;
                default: cpu_ce_q <= 1'b0;
            endcase
        end
    end

    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.heartbeat = heartbeat_q;
    assign bus.state     = state_q;

`ifdef CE_COUNT_EN
    logic [31:0] ce_count_q;

    always_ff @(posedge clk_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            ce_count_q <= '0;
        end else if (cpu_ce_q) begin
            ce_count_q <= ce_count_q + 32'd1;
        end
    end

    assign bus.ce_count = ce_count_q;
`endif

endmodule
